// File: rtl/lzrw1_group_packer.sv
`default_nettype none
// ============================================================================
//  Module   : lzrw1_group_packer
//  Purpose  : Collects LZRW1 items (literal bytes or {length, offset} copies)
//             into groups of up to 16. Each finished group goes out as a byte
//             stream: the 16-bit control word (low byte first), then the item
//             bytes. The module also handles end-of-stream flushing.
//  Ports    : clock, reset        - rising-edge clock, sync active-high reset
//             item_valid/ready    - item handshake
//             item_is_copy        - 1 = copy item, 0 = literal
//             item_length/offset  - copy fields; item_literal - literal byte
//             flush               - single-cycle end-of-stream request
//             out_valid/ready     - output byte handshake; out_data = byte
//             out_last            - final byte of the whole stream
//             finished            - sticky completion flag
//             bytes_emitted       - count of transferred bytes (mod 2^16)
//  Revision : 1.0  initial release
// ============================================================================
module lzrw1_group_packer #(
  parameter int MAX_ITEMS = 16,
  parameter int BUF_BYTES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        item_valid,
  output logic        item_ready,
  input  logic        item_is_copy,
  input  logic [3:0]  item_length,
  input  logic [11:0] item_offset,
  input  logic [7:0]  item_literal,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        finished,
  output logic [15:0] bytes_emitted
);

  localparam int CW = $clog2(MAX_ITEMS + 1);  // item counter width
  localparam int BW = $clog2(BUF_BYTES + 1);  // byte counter width
  localparam int AW = $clog2(BUF_BYTES);      // buffer address width

  typedef enum logic [2:0] {
    S_FILL    = 3'd0,
    S_CTRL_LO = 3'd1,
    S_CTRL_HI = 3'd2,
    S_DATA    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_item_count;
  logic [BW-1:0]          r_byte_count;
  logic [MAX_ITEMS-1:0]   r_ctrl;
  logic [BW-1:0]          r_rd_ptr;
  logic                   r_pending_flush;
  logic [7:0]             r_buf [BUF_BYTES];

  logic                   w_accept;
  logic                   w_xfer;
  logic                   w_pend;
  logic [CW-1:0]          w_count_next;
  logic [BW-1:0]          w_bytes_next;
  logic [MAX_ITEMS-1:0]   w_ctrl_next;
  logic [BW-1:0]          w_rd_next;
  logic [BW-1:0]          w_last_idx;
  logic [AW-1:0]          w_wr0;
  logic [AW-1:0]          w_wr1;

  always_comb begin
    w_accept     = item_valid & item_ready;
    w_xfer       = out_valid & out_ready;
    // A flush seen this cycle counts as already pending, so a request that
    // lands on the final byte of a group still ends the stream.
    w_pend       = r_pending_flush | flush;
    w_count_next = r_item_count + CW'(w_accept);
    w_bytes_next = r_byte_count;
    w_ctrl_next  = r_ctrl;
    if (w_accept) begin
      w_bytes_next = r_byte_count + (item_is_copy ? BW'(2) : BW'(1));
      if (item_is_copy)
        w_ctrl_next = r_ctrl | (MAX_ITEMS'(1) << r_item_count);
    end
    w_rd_next  = r_rd_ptr + BW'(1);
    w_last_idx = r_byte_count - BW'(1);
    w_wr0      = r_byte_count[AW-1:0];
    w_wr1      = w_wr0 + AW'(1);
  end

  // Item byte storage; accepts only happen in FILL, so no read/write overlap.
  always_ff @(posedge clock) begin
    if (!reset && w_accept) begin
      if (item_is_copy) begin
        r_buf[w_wr0] <= {item_length, item_offset[11:8]};
        r_buf[w_wr1] <= item_offset[7:0];
      end else begin
        r_buf[w_wr0] <= item_literal;
      end
    end
  end

  // Sequencer with registered outputs: every output is loaded with the value
  // that belongs to the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_FILL;
      r_item_count    <= '0;
      r_byte_count    <= '0;
      r_ctrl          <= '0;
      r_rd_ptr        <= '0;
      r_pending_flush <= 1'b0;
      item_ready      <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= 8'h00;
      out_last        <= 1'b0;
      finished        <= 1'b0;
      bytes_emitted   <= 16'h0000;
    end else begin
      if (w_xfer)
        bytes_emitted <= bytes_emitted + 16'd1;

      case (r_state)
        S_FILL: begin
          r_item_count <= w_count_next;
          r_byte_count <= w_bytes_next;
          r_ctrl       <= w_ctrl_next;
          if ((w_accept && (w_count_next == CW'(MAX_ITEMS))) ||
              (flush && (w_count_next != '0))) begin
            r_state    <= S_CTRL_LO;
            item_ready <= 1'b0;
            out_valid  <= 1'b1;
            out_data   <= w_ctrl_next[7:0];
            if (flush)
              r_pending_flush <= 1'b1;
          end else if (flush) begin
            // Nothing buffered: the stream ends without another group.
            r_state    <= S_DONE;
            item_ready <= 1'b0;
            finished   <= 1'b1;
          end else begin
            item_ready <= 1'b1;
          end
        end

        S_CTRL_LO: begin
          r_pending_flush <= w_pend;
          if (w_xfer) begin
            r_state  <= S_CTRL_HI;
            out_data <= r_ctrl[15:8];
          end
        end

        S_CTRL_HI: begin
          r_pending_flush <= w_pend;
          if (w_xfer) begin
            r_state  <= S_DATA;
            r_rd_ptr <= '0;
            out_data <= r_buf[0];
            out_last <= w_pend && (r_byte_count == BW'(1));
          end
        end

        S_DATA: begin
          r_pending_flush <= w_pend;
          if (w_xfer && (r_rd_ptr == w_last_idx)) begin
            r_item_count <= '0;
            r_byte_count <= '0;
            r_ctrl       <= '0;
            r_rd_ptr     <= '0;
            out_valid    <= 1'b0;
            out_data     <= 8'h00;
            out_last     <= 1'b0;
            if (w_pend) begin
              r_state  <= S_DONE;
              finished <= 1'b1;
            end else begin
              r_state    <= S_FILL;
              item_ready <= 1'b1;
            end
          end else if (w_xfer) begin
            r_rd_ptr <= w_rd_next;
            out_data <= r_buf[w_rd_next[AW-1:0]];
            out_last <= w_pend && (w_rd_next == w_last_idx);
          end else begin
            // Stalled: data holds; out_last may rise if a flush just arrived.
            out_last <= w_pend && (r_rd_ptr == w_last_idx);
          end
        end

        S_DONE: begin
          item_ready <= 1'b0;
          out_valid  <= 1'b0;
        end

        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lzrw1_group_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lzrw1_group_packer
//  Purpose  : Directed, self-checking bench for lzrw1_group_packer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lzrw1_group_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        item_valid = 1'b0;
  logic        item_ready;
  logic        item_is_copy = 1'b0;
  logic [3:0]  item_length = 4'h0;
  logic [11:0] item_offset = 12'h000;
  logic [7:0]  item_literal = 8'h00;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        finished;
  logic [15:0] bytes_emitted;

  lzrw1_group_packer dut (
    .clock(clock), .reset(reset),
    .item_valid(item_valid), .item_ready(item_ready),
    .item_is_copy(item_is_copy), .item_length(item_length),
    .item_offset(item_offset), .item_literal(item_literal),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .finished(finished), .bytes_emitted(bytes_emitted)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  always @(posedge clock) cyc++;

  // Output ready: either a fixed level or a 30%-duty random pattern.
  logic rdy_level = 1'b1;
  logic rand_rdy  = 1'b0;
  logic rnd_bit   = 1'b0;
  always @(posedge clock) begin
    #1 rnd_bit = ($urandom_range(0, 9) < 3);
  end
  assign out_ready = rand_rdy ? rnd_bit : rdy_level;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Output collector, stall-stability and handshake monitors.
  logic [7:0] q_data[$];
  bit         q_last[$];
  int         last_xfer_cyc = -1;
  int         accepts = 0;
  bit         stall_prev = 0;
  logic [7:0] stall_data = 8'h00;
  bit         rdy_viol = 0;

  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev)
        check("stall_hold", {out_valid, out_data}, {1'b1, stall_data});
      if (out_valid && item_ready) rdy_viol = 1;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_last.push_back(out_last);
        if (out_last) last_xfer_cyc = cyc;
      end
      if (item_valid && item_ready) accepts++;
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    item_valid = 1'b0;
    flush = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    q_data.delete();
    q_last.delete();
    last_xfer_cyc = -1;
    accepts = 0;
    rdy_viol = 0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clock);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_finished"}, finished, 0);
    check({tag, "_bytes"}, bytes_emitted, 0);
    check({tag, "_item_ready"}, item_ready, 0);
  endtask

  task automatic send(input bit c, input logic [3:0] l, input logic [11:0] o,
                      input logic [7:0] lit);
    int k;
    item_valid = 1'b1;
    item_is_copy = c;
    item_length = l;
    item_offset = o;
    item_literal = lit;
    k = 0;
    @(negedge clock);
    while (!item_ready && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (!item_ready) $display("FAIL send_wait: got item_ready=0, expected 1");
    @(posedge clock);
    #1;
    item_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_finished(output int fin_cyc);
    int k;
    k = 0;
    @(negedge clock);
    while (!finished && k < 600) begin
      @(negedge clock);
      k++;
    end
    check("finished_rise", finished, 1);
    fin_cyc = cyc;
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (q_data.size() < n && k < 600) begin
      @(negedge clock);
      k++;
    end
    check("wait_bytes", q_data.size() >= n, 1);
  endtask

  logic [7:0] exp_q[$];

  task automatic compare_stream(input string name, input int last_idx);
    int n;
    check({name, "_len"}, q_data.size(), exp_q.size());
    n = (q_data.size() < exp_q.size()) ? q_data.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", name, i), q_data[i], exp_q[i]);
      check($sformatf("%s_last%0d", name, i), q_last[i], (i == last_idx) ? 1 : 0);
    end
  endtask

  typedef struct {
    bit          c;
    logic [3:0]  l;
    logic [11:0] o;
    logic [7:0]  lit;
    int          nb;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t vecs[5];
  int   fc;

  initial begin
    // Mixed group for the backpressure test; b0/b1 are the expected bytes.
    vecs[0] = '{0, 4'h0, 12'h000, 8'h11, 1, 8'h11, 8'h00};
    vecs[1] = '{1, 4'h2, 12'h345, 8'h00, 2, 8'h23, 8'h45};
    vecs[2] = '{0, 4'h0, 12'h000, 8'h22, 1, 8'h22, 8'h00};
    vecs[3] = '{1, 4'hF, 12'hFFF, 8'h00, 2, 8'hFF, 8'hFF};
    vecs[4] = '{0, 4'h0, 12'h000, 8'h33, 1, 8'h33, 8'h00};

    // ---- 1: 16 literals, flush during emission ----
    do_reset();
    check_idle("reset1");
    rdy_level = 1'b1;
    for (int i = 0; i < 16; i++) send(0, 4'h0, 12'h000, 8'h41 + 8'(i));
    @(negedge clock);
    check("t1_ctrl_latency", out_valid, 1);
    pulse_flush();
    wait_finished(fc);
    check("t1_fin_after_last", fc, last_xfer_cyc + 1);
    exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h41 + 8'(i));
    compare_stream("t1", 17);
    check("t1_bytes", bytes_emitted, 18);

    // ---- 2: literal + copy, flush in FILL ----
    do_reset();
    send(0, 4'h0, 12'h000, 8'h61);
    send(1, 4'h3, 12'h123, 8'h00);
    pulse_flush();
    @(negedge clock);
    check("t2_flush_latency", out_valid, 1);
    wait_finished(fc);
    exp_q = '{8'h02, 8'h00, 8'h61, 8'h31, 8'h23};
    compare_stream("t2", 4);
    check("t2_bytes", bytes_emitted, 5);

    // ---- 3: 16 copies, then flush of an empty group ----
    do_reset();
    for (int i = 0; i < 16; i++) send(1, 4'hF, 12'hABC, 8'h00);
    wait_bytes(34);
    tick();
    tick();
    @(negedge clock);
    check("t3_ready_after_drain", item_ready, 1);
    pulse_flush();
    wait_finished(fc);
    tick();
    tick();
    exp_q.delete();
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'hFA);
      exp_q.push_back(8'hBC);
    end
    compare_stream("t3", -1);
    check("t3_bytes", bytes_emitted, 34);

    // ---- 4: flush with nothing accepted ----
    do_reset();
    pulse_flush();
    @(negedge clock);
    check("t4_finished", finished, 1);
    tick();
    tick();
    @(negedge clock);
    check("t4_no_output", q_data.size(), 0);
    check("t4_out_valid", out_valid, 0);
    check("t4_bytes", bytes_emitted, 0);

    // ---- 5: random 30% backpressure ----
    do_reset();
    rand_rdy = 1'b1;
    exp_q = '{8'h0A, 8'h00};
    foreach (vecs[i]) begin
      send(vecs[i].c, vecs[i].l, vecs[i].o, vecs[i].lit);
      exp_q.push_back(vecs[i].b0);
      if (vecs[i].nb == 2) exp_q.push_back(vecs[i].b1);
    end
    pulse_flush();
    wait_finished(fc);
    rand_rdy = 1'b0;
    compare_stream("t5", exp_q.size() - 1);
    check("t5_ready_held_low", rdy_viol, 0);
    check("t5_bytes", bytes_emitted, 9);

    // ---- 6: flush mid-DATA with items offered, then reset mid-CTRL_HI ----
    do_reset();
    rdy_level = 1'b1;
    for (int i = 0; i < 16; i++) send(0, 4'h0, 12'h000, 8'h10 + 8'(i));
    accepts = 0;
    wait_bytes(5);
    pulse_flush();
    for (int j = 0; j < 3; j++) begin
      item_valid = 1'b1;
      item_is_copy = 1'b0;
      item_literal = 8'hA0 + 8'(j);
      tick();
      tick();
    end
    item_valid = 1'b1;
    wait_finished(fc);
    tick();
    tick();
    item_valid = 1'b0;
    check("t6_no_accepts", accepts, 0);
    exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
    compare_stream("t6", 17);
    check("t6_bytes", bytes_emitted, 18);

    do_reset();
    rdy_level = 1'b0;
    for (int i = 0; i < 16; i++) send(0, 4'h0, 12'h000, 8'h30 + 8'(i));
    tick();
    rdy_level = 1'b1;
    tick();
    rdy_level = 1'b0;
    @(negedge clock);
    check("t6_ctrl_hi_valid", out_valid, 1);
    check("t6_ctrl_hi_bytes", bytes_emitted, 1);
    tick();
    do_reset();
    check_idle("reset6");
    rdy_level = 1'b1;
    send(0, 4'h0, 12'h000, 8'h77);
    pulse_flush();
    wait_finished(fc);
    exp_q = '{8'h00, 8'h00, 8'h77};
    compare_stream("t6b", 2);
    check("t6b_bytes", bytes_emitted, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
